// File: rtl/fixed_to_float_ctrl.sv
// Multi-cycle signed fixed-point to IEEE-754 single converter.
// Normalises by shifting one bit per cycle; the mantissa is truncated.
module fixed_to_float_ctrl #(
    parameter int FRAC_BITS = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        BEG_FSM,
    input  logic        ACK_FF,
    input  logic [31:0] fixed_i,
    output logic [31:0] float_o,
    output logic        busy_o,
    output logic        RDY_FF
);

    typedef enum logic [2:0] {
        IDLE,
        COMP,
        NORM,
        PACK,
        DONE
    } state_t;

    localparam logic [8:0] EXP_BASE = 9'(127 + 31 - FRAC_BITS);

    state_t      state;
    logic        sign;
    logic        zero;
    logic [31:0] x;
    logic [31:0] mag;
    logic [4:0]  shift_cnt;

    logic [31:0] mag_w;
    logic [8:0]  exp_w;
    logic [31:0] pack_w;

    assign mag_w = sign ? (~x + 32'd1) : x;
    assign exp_w = EXP_BASE - {4'd0, shift_cnt};

    // exp_w[8] is always 0 for legal FRAC_BITS, so it never disturbs the sign bit
    assign pack_w = {exp_w, mag[30:8]} | {sign, 31'd0};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            sign      <= 1'b0;
            zero      <= 1'b0;
            x         <= '0;
            mag       <= '0;
            shift_cnt <= '0;
            float_o   <= '0;
            busy_o    <= 1'b0;
            RDY_FF    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (BEG_FSM) begin
                        sign      <= fixed_i[31];
                        x         <= fixed_i;
                        shift_cnt <= '0;
                        zero      <= 1'b0;
                        busy_o    <= 1'b1;
                        state     <= COMP;
                    end
                end
                COMP: begin
                    mag   <= mag_w;
                    zero  <= (mag_w == 32'd0);
                    state <= (mag_w == 32'd0) ? PACK : NORM;
                end
                NORM: begin
                    if (mag[31]) begin
                        state <= PACK;
                    end else begin
                        mag       <= mag << 1;
                        shift_cnt <= shift_cnt + 5'd1;
                    end
                end
                PACK: begin
                    float_o <= zero ? 32'd0 : pack_w;
                    RDY_FF  <= 1'b1;
                    state   <= DONE;
                end
                DONE: begin
                    if (ACK_FF) begin
                        RDY_FF <= 1'b0;
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fixed_to_float_ctrl.sv
// Self-checking bench for fixed_to_float_ctrl with FRAC_BITS=16.
// Expected results come from an arithmetic model of the conversion.
module tb_fixed_to_float_ctrl;

    localparam int FRAC = 16;

    logic        CLK;
    logic        RST;
    logic        BEG_FSM;
    logic        ACK_FF;
    logic [31:0] fixed_i;
    logic [31:0] float_o;
    logic        busy_o;
    logic        RDY_FF;

    int checks;
    int errors;

    fixed_to_float_ctrl #(.FRAC_BITS(FRAC)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .BEG_FSM(BEG_FSM),
        .ACK_FF (ACK_FF),
        .fixed_i(fixed_i),
        .float_o(float_o),
        .busy_o (busy_o),
        .RDY_FF (RDY_FF)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Value = signed(v) / 2^FRAC; result truncated toward zero.
    function automatic void model(input logic [31:0] v,
                                  output logic [31:0] f,
                                  output int lat);
        longint m;
        longint rem;
        int p;
        int e;
        logic [22:0] man;
        m = longint'($signed(v));
        if (m < 0) m = -m;
        if (m == 0) begin
            f   = 32'd0;
            lat = 3;
            return;
        end
        p = 0;
        for (int i = 0; i < 33; i++)
            if (m >= (longint'(1) << i)) p = i;
        e   = 127 + p - FRAC;
        rem = m - (longint'(1) << p);
        if (p >= 23) man = 23'(rem >> (p - 23));
        else         man = 23'(rem << (23 - p));
        f   = {v[31], 8'(e), man};
        lat = 4 + (31 - p);
    endfunction

    // Start a conversion; lat counts edges with the start edge as 1.
    // hold_bad flags any float_o change before RDY_FF rises.
    task automatic convert(input logic [31:0] v,
                           output logic [31:0] res,
                           output int lat,
                           output bit hold_bad);
        logic [31:0] prev;
        int cyc;
        @(negedge CLK);
        prev     = float_o;
        hold_bad = 1'b0;
        fixed_i  = v;
        BEG_FSM  = 1'b1;
        cyc      = 0;
        do begin
            @(negedge CLK);
            cyc++;
            BEG_FSM = 1'b0;
            fixed_i = $urandom;
            if (!RDY_FF && float_o !== prev) hold_bad = 1'b1;
        end while (!RDY_FF && cyc < 100);
        res = float_o;
        lat = RDY_FF ? cyc : -1;
    endtask

    task automatic do_ack();
        @(negedge CLK);
        ACK_FF = 1'b1;
        @(negedge CLK);
        ACK_FF = 1'b0;
    endtask

    task automatic check_conv(input string name, input logic [31:0] v);
        logic [31:0] res;
        logic [31:0] ef;
        int lat;
        int el;
        bit hb;
        model(v, ef, el);
        convert(v, res, lat, hb);
        checks += 3;
        if (res !== ef) begin
            errors++;
            $display("FAIL %s value in=%h got=%h want=%h", name, v, res, ef);
        end
        if (lat !== el) begin
            errors++;
            $display("FAIL %s latency in=%h got=%0d want=%0d", name, v, lat, el);
        end
        if (hb) begin
            errors++;
            $display("FAIL %s float_o moved before ready in=%h got=1 want=0",
                     name, v);
        end
        do_ack();
        checks++;
        if (RDY_FF !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL %s ack rdy/busy got=%b%b want=00", name, RDY_FF, busy_o);
        end
    endtask

    task automatic test_reset();
        RST     = 1'b1;
        BEG_FSM = 1'b0;
        ACK_FF  = 1'b0;
        fixed_i = '0;
        #2;
        checks++;
        if (float_o !== 32'd0 || busy_o !== 1'b0 || RDY_FF !== 1'b0) begin
            errors++;
            $display("FAIL reset outputs got=%h/%b/%b want=0/0/0",
                     float_o, busy_o, RDY_FF);
        end
        repeat (2) @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_directed();
        logic [31:0] ef;
        int el;
        model(32'h0001_0000, ef, el);
        checks++;
        if (ef !== 32'h3F80_0000 || el != 19) begin
            errors++;
            $display("FAIL model_sanity got=%h/%0d want=3f800000/19", ef, el);
        end
        check_conv("plus_one",  32'h0001_0000);
        check_conv("minus_one", 32'hFFFF_0000);
        check_conv("most_neg",  32'h8000_0000);
        check_conv("zero",      32'h0000_0000);
        check_conv("lsb",       32'h0000_0001);
        check_conv("max_pos",   32'h7FFF_FFFF);
        check_conv("minus_lsb", 32'hFFFF_FFFF);
    endtask

    task automatic test_random();
        logic [31:0] v;
        for (int i = 0; i < 40; i++) begin
            v = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) v = -v;
            if (i % 13 == 12) v = 32'd0;
            check_conv("random", v);
        end
    endtask

    task automatic test_hold_done();
        logic [31:0] res;
        logic [31:0] ef;
        int lat;
        int el;
        bit hb;
        bit bad;
        model(32'h0003_8000, ef, el);
        convert(32'h0003_8000, res, lat, hb);
        checks++;
        if (res !== ef) begin
            errors++;
            $display("FAIL hold_conv got=%h want=%h", res, ef);
        end
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            BEG_FSM = ~BEG_FSM;
            fixed_i = $urandom;
            if (RDY_FF !== 1'b1 || float_o !== ef) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL hold_done got=%b/%h want=1/%h", RDY_FF, float_o, ef);
        end
        @(negedge CLK);
        ACK_FF  = 1'b1;
        BEG_FSM = 1'b1;
        fixed_i = 32'h0001_0000;
        @(negedge CLK);
        ACK_FF  = 1'b0;
        BEG_FSM = 1'b0;
        checks++;
        if (RDY_FF !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL ack_with_beg got=%b%b want=00", RDY_FF, busy_o);
        end
        repeat (3) @(negedge CLK);
        checks++;
        if (busy_o !== 1'b0 || float_o !== ef) begin
            errors++;
            $display("FAIL no_queue got=%b/%h want=0/%h", busy_o, float_o, ef);
        end
    endtask

    task automatic test_async_reset();
        bit rdy_seen;
        @(negedge CLK);
        fixed_i = 32'h0000_0001;
        BEG_FSM = 1'b1;
        @(negedge CLK);
        BEG_FSM = 1'b0;
        repeat (10) @(negedge CLK);
        checks++;
        if (busy_o !== 1'b1 || float_o === 32'd0) begin
            errors++;
            $display("FAIL pre_reset got=%b/%h want=1/nonzero", busy_o, float_o);
        end
        @(posedge CLK);
        #3;
        RST = 1'b1;
        #1;
        checks++;
        if (float_o !== 32'd0 || busy_o !== 1'b0 || RDY_FF !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got=%h/%b/%b want=0/0/0",
                     float_o, busy_o, RDY_FF);
        end
        rdy_seen = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            if (RDY_FF) rdy_seen = 1'b1;
        end
        RST = 1'b0;
        repeat (40) begin
            @(negedge CLK);
            if (RDY_FF || busy_o) rdy_seen = 1'b1;
        end
        checks++;
        if (rdy_seen) begin
            errors++;
            $display("FAIL aborted_conv got=1 want=0");
        end
        check_conv("after_reset", 32'h0001_0000);
    endtask

    task automatic test_back_to_back();
        check_conv("b2b_a", 32'h0000_4000);
        check_conv("b2b_b", 32'hC000_0000);
        check_conv("b2b_c", 32'h0000_0000);
        check_conv("b2b_d", 32'h1234_5678);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_directed();
        test_hold_done();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
